// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the dmem arbiter.
//   arb_state_e  - arbiter FSM states (idle, issue, wait)
//   PORT_CPU/DBG - requester index constants
//   MEM_LAT_MAX  - largest supported syncram read latency
//   CNT_W        - width of the latency down-counter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_e;

  localparam int unsigned PORT_CPU    = 0;
  localparam int unsigned PORT_DBG    = 1;
  localparam int unsigned MEM_LAT_MAX = 3;
  localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req    - request vector, bit n = port n
//   last   - port granted most recently
//   valid  - at least one request present
//   winner - selected port index
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'(PORT_CPU);
    if (req == 2'b11) begin
      // Tie: the port that did not win last time goes first.
      winner = ~last;
    end else if (req[PORT_DBG]) begin
      winner = 1'(PORT_DBG);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem syncram between the CPU load/store
// path (port 0) and the debug/loader requester (port 1). One access in flight.
//   clock, reset                 - single clock, synchronous active-high reset
//   req/we/addr/wdata 0,1        - requester side, req held until gnt
//   gnt 0,1 / rvalid 0,1 / rdata - one-cycle grant and read-return pulses
//   mem_address/mem_data/mem_wren/mem_q - registered dmem interface
//   busy                         - arbiter not idle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              rd_q, rd_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_valid, pick_winner, win_we;

  rr_pick2 u_pick (
    .req    ({req1, req0}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign win_we = pick_winner ? we1 : we0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StIssue;
          last_d  = pick_winner;
          owner_d = pick_winner;
          rd_d    = ~win_we;
          addr_d  = pick_winner ? addr1 : addr0;
          data_d  = pick_winner ? wdata1 : wdata0;
          wren_d  = win_we;
          gnt0_d  = (pick_winner == 1'(PORT_CPU));
          gnt1_d  = (pick_winner == 1'(PORT_DBG));
        end
      end
      StIssue: begin
        if (rd_q) begin
          state_d = StWait;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          rdata_d = mem_q;
          rv0_d   = (owner_q == 1'(PORT_CPU));
          rv1_d   = (owner_q == 1'(PORT_DBG));
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rv0_q;
  assign rvalid1     = rv1_q;
  assign rdata       = rdata_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  // A write sitting in ISSUE must not reach dmem while reset is asserted.
  assign mem_wren    = wren_q & ~reset;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Instance u_dut uses
// MEM_LAT=1, instance u_dut3 uses MEM_LAT=3. Expected grants come from a
// round-robin model (last-granted port), expected read data from ref_mem.
module tb_dmem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1, mem_address;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_data, mem_q;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy;

  logic          b_req0, b_we0;
  logic [AW-1:0] b_addr0, b_mem_address;
  logic [DW-1:0] b_wdata0, b_rdata, b_mem_data, b_mem_q;
  logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_wren, b_busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
    .addr0(b_addr0), .addr1({AW{1'b0}}), .wdata0(b_wdata0), .wdata1({DW{1'b0}}),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata(b_rdata), .mem_address(b_mem_address), .mem_data(b_mem_data),
    .mem_wren(b_mem_wren), .mem_q(b_mem_q), .busy(b_busy)
  );

  // Syncram models with a backdoor preload port.
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] q_a;
  logic [DW-1:0] q_b [3];

  always @(posedge clock) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (mem_wren) mem_a[mem_address] <= mem_data;
    q_a <= mem_a[mem_address];
  end
  assign mem_q = q_a;

  always @(posedge clock) begin
    if (pl_en) mem_b[pl_addr] <= pl_data;
    q_b[0] <= mem_b[b_mem_address];
    q_b[1] <= q_b[0];
    q_b[2] <= q_b[1];
  end
  assign b_mem_q = q_b[2];

  // Reference state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          p_req  [2];
  logic          p_we   [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];
  int            m_last;
  int            rv_cnt [2];
  int            checks = 0;
  int            errors = 0;

  task automatic drive();
    req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_data[0];
    req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_data[1];
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_data[p] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // One full transaction on u_dut: grant, then read return if it is a read.
  task automatic do_txn(input int exp_wait, output int w);
    int n;
    logic seen, bad_gnt, wr;
    logic [AW-1:0] a;
    if (p_req[0] && p_req[1]) w = 1 - m_last;
    else if (p_req[1]) w = 1;
    else w = 0;
    drive();
    seen = 1'b0; n = 0;
    while (!seen && n < 8) begin
      @(negedge clock); n++; seen = gnt0 | gnt1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL gnt_timeout: no grant in %0d cycles, want port %0d", n, w);
      return;
    end
    checks++;
    if ({gnt1, gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL grant_port: gnt1,gnt0=%b want port %0d", {gnt1, gnt0}, w);
    end
    checks++;
    if (n !== exp_wait) begin
      errors++; $display("FAIL grant_latency: %0d cycles want %0d", n, exp_wait);
    end
    checks++;
    if (mem_address !== p_addr[w]) begin
      errors++; $display("FAIL mem_address: %h want %h", mem_address, p_addr[w]);
    end
    checks++;
    if (mem_wren !== p_we[w]) begin
      errors++; $display("FAIL mem_wren: %b want %b", mem_wren, p_we[w]);
    end
    checks++;
    if (p_we[w] && mem_data !== p_data[w]) begin
      errors++; $display("FAIL mem_data: %h want %h", mem_data, p_data[w]);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_issue: %b want 1", busy);
    end
    m_last = w; wr = p_we[w]; a = p_addr[w];
    p_req[w] = 1'b0;
    drive();
    if (wr) begin
      ref_mem[a] = p_data[w];
    end else begin
      seen = 1'b0; n = 0; bad_gnt = 1'b0;
      while (!seen && n < 8) begin
        @(negedge clock); n++;
        if (gnt0 | gnt1) bad_gnt = 1'b1;
        seen = rvalid0 | rvalid1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rvalid_timeout: none in %0d cycles", n);
        return;
      end
      checks++;
      if ({rvalid1, rvalid0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rvalid_port: %b want port %0d", {rvalid1, rvalid0}, w);
      end
      checks++;
      if (n !== 2) begin
        errors++; $display("FAIL read_latency: %0d cycles after gnt want 2", n);
      end
      checks++;
      if (rdata !== ref_mem[a]) begin
        errors++; $display("FAIL rdata: %h want %h (addr %h)", rdata, ref_mem[a], a);
      end
      checks++;
      if (bad_gnt !== 1'b0) begin
        errors++; $display("FAIL gnt_while_busy: got 1 want 0");
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL busy_rvalid: %b want 0", busy);
      end
      rv_cnt[w]++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: %b want 000000",
                         {gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy});
    end
    checks++;
    if ({mem_address, mem_data, rdata} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h data=%h rdata=%h want 0",
                         mem_address, mem_data, rdata);
    end
    checks++;
    if ({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_rdata} !== '0) begin
      errors++; $display("FAIL reset_lat3: outputs not 0");
    end
    reset = 1'b0;
    m_last = 1;
    @(negedge clock);
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b0) begin
      errors++; $display("FAIL post_reset_idle: %b want 000", {gnt0, gnt1, busy});
    end
  endtask

  task automatic test_latency_sweep();
    int busy_cnt, rv_at;
    logic [DW-1:0] rd;
    logic wren_seen;
    busy_cnt = 0; rv_at = -1; rd = '0; wren_seen = 1'b0;
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 12'd7; b_wdata0 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (b_gnt0) b_req0 = 1'b0;
      if (b_busy) busy_cnt++;
      if (b_mem_wren) wren_seen = 1'b1;
      if ((b_rvalid0 || b_rvalid1) && rv_at < 0) begin
        rv_at = b_rvalid1 ? -2 : c; rd = b_rdata;
      end
    end
    b_req0 = 1'b0;
    checks++;
    if (rv_at !== 5) begin
      errors++; $display("FAIL lat3_rvalid_cycle: %0d want 5", rv_at);
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++; $display("FAIL lat3_busy_cycles: %0d want 4", busy_cnt);
    end
    checks++;
    if (rd !== ref_mem[7]) begin
      errors++; $display("FAIL lat3_rdata: %h want %h", rd, ref_mem[7]);
    end
    checks++;
    if ({wren_seen, b_mem_data} !== '0) begin
      errors++; $display("FAIL lat3_no_write: wren=%b data=%h want 0", wren_seen, b_mem_data);
    end
  endtask

  task automatic test_read_after_reset();
    int w;
    rv_cnt[0] = 0; rv_cnt[1] = 0;
    set_req(0, 1'b0, 12'd5, '0);
    do_txn(1, w);
    checks++;
    if (rdata !== 32'hDEADBEEF || rv_cnt[1] !== 0) begin
      errors++; $display("FAIL read_after_reset: rdata=%h rv1=%0d want deadbeef 0",
                         rdata, rv_cnt[1]);
    end
  endtask

  task automatic test_write_then_read();
    int w;
    set_req(1, 1'b1, 12'hFFF, 32'h12345678);
    do_txn(1, w);
    @(negedge clock);
    checks++;
    if ({mem_wren, gnt1} !== 2'b00) begin
      errors++; $display("FAIL wren_one_cycle: wren,gnt1=%b want 00", {mem_wren, gnt1});
    end
    set_req(1, 1'b0, 12'hFFF, '0);
    do_txn(1, w);
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++; $display("FAIL write_read_back: %h want 12345678", rdata);
    end
  endtask

  task automatic test_fairness();
    int w, prev;
    int sent [2];
    rv_cnt[0] = 0; rv_cnt[1] = 0; sent[0] = 0; sent[1] = 0; prev = -1;
    set_req(0, 1'b0, 12'($urandom_range(0, 15)), '0);
    set_req(1, 1'b0, 12'($urandom_range(0, 15)), '0);
    for (int i = 0; i < 16; i++) begin
      do_txn(1, w);
      checks++;
      if (w == prev) begin
        errors++; $display("FAIL alternation: port %0d granted twice at %0d", w, i);
      end
      prev = w;
      sent[w]++;
      if (sent[w] < 8) set_req(w, 1'b0, 12'($urandom_range(0, 15)), '0);
    end
    checks++;
    if (rv_cnt[0] !== 8 || rv_cnt[1] !== 8) begin
      errors++; $display("FAIL fair_rvalid_count: %0d/%0d want 8/8", rv_cnt[0], rv_cnt[1]);
    end
  endtask

  task automatic test_late_request();
    int n;
    logic [DW-1:0] d;
    d = $urandom;
    set_req(0, 1'b0, 12'd9, '0);
    drive();
    n = 0;
    do begin @(negedge clock); n++; end while (!gnt0 && n < 8);
    p_req[0] = 1'b0; drive();
    @(negedge clock);
    set_req(1, 1'b1, 12'd10, d); drive();
    @(negedge clock);
    checks++;
    if ({rvalid0, gnt1} !== 2'b10 || rdata !== ref_mem[9]) begin
      errors++; $display("FAIL late_rvalid0: rvalid0,gnt1=%b rdata=%h want 10 %h",
                         {rvalid0, gnt1}, rdata, ref_mem[9]);
    end
    @(negedge clock);
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++; $display("FAIL late_gnt1: %b want 1", gnt1);
    end
    p_req[1] = 1'b0; drive();
    ref_mem[10] = d; m_last = 1;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int n, w;
    logic seen;
    set_req(0, 1'b0, 12'd3, '0); drive();
    n = 0;
    do begin @(negedge clock); n++; end while (!gnt0 && n < 8);
    p_req[0] = 1'b0; drive();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy} !== 6'b0 ||
        {mem_address, mem_data, rdata} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: ctrl=%b addr=%h rdata=%h want 0",
                         {gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy}, mem_address, rdata);
    end
    reset = 1'b0; m_last = 1;
    seen = 1'b0;
    repeat (4) begin @(negedge clock); if (rvalid0 | rvalid1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abandoned_rvalid: got 1 want 0");
    end
    // Write granted, then reset lands during its ISSUE cycle.
    set_req(1, 1'b1, 12'd2, ~ref_mem[2]); drive();
    n = 0;
    do begin @(negedge clock); n++; end while (!gnt1 && n < 8);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wren !== 1'b0) begin
      errors++; $display("FAIL wren_under_reset: %b want 0", mem_wren);
    end
    p_req[1] = 1'b0; drive();
    @(negedge clock);
    reset = 1'b0; m_last = 1;
    // Tie after reset goes to port 0; addr 2 must still hold the old data.
    set_req(0, 1'b0, 12'd2, '0);
    set_req(1, 1'b0, 12'd3, '0);
    do_txn(1, w);
    do_txn(1, w);
  endtask

  task automatic test_random();
    int w, exp_wait, p;
    exp_wait = 1;
    for (int i = 0; i < 40; i++) begin
      for (int q = 0; q < 2; q++) begin
        if (!p_req[q] && $urandom_range(0, 1) == 1)
          set_req(q, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15)),
                  $urandom);
      end
      if (!p_req[0] && !p_req[1]) begin
        p = int'($urandom_range(0, 1));
        set_req(p, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      end
      do_txn(exp_wait, w);
      exp_wait = p_we[w] ? 2 : 1;
    end
    while (p_req[0] || p_req[1]) begin
      do_txn(exp_wait, w);
      exp_wait = p_we[w] ? 2 : 1;
    end
    @(negedge clock);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_data[p] = '0;
    end
    drive();
    @(negedge clock);
    for (int a = 0; a < 16; a++) preload(12'(a), $urandom);
    preload(12'hFFF, $urandom);
    preload(12'd5, 32'hDEADBEEF);
    test_reset();
    test_latency_sweep();
    test_read_after_reset();
    test_write_then_read();
    test_fairness();
    test_late_request();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
